mem_dbg_arbiter: RTL and testbench

Shares the A/D/*A memory block between the CPU core and a debug/loader port. The block drives the memory's x and write[2:0] inputs. CPU traffic passes straight through when idle. Debug read/write transactions to an arbitrary address are sequenced by an FSM that stalls the CPU, loads A, performs the access, then restores the CPU's A register so the debug access is invisible to the program.

---
 rtl/mem_dbg_arbiter_if.sv | 33 +++
 rtl/mem_dbg_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_dbg_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dbg_arbiter_if.sv
// Bundle of CPU, memory-block and debug-port signals shared by the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface mem_dbg_arbiter_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] cpu_x;
  logic [2:0]        cpu_write;
  logic              cpu_stall;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] a_mem_reg;
  logic [DATA_W-1:0] mem_x;
  logic [2:0]        mem_write;
  logic              dbg_valid;
  logic              dbg_ready;
  logic              dbg_we;
  logic [DATA_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_rsp_valid;
  logic              dbg_rsp_ready;
  logic [DATA_W-1:0] dbg_rdata;

  modport slave (
    input  cpu_x, cpu_write, a_reg, a_mem_reg,
    input  dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_rsp_ready,
    output cpu_stall, mem_x, mem_write, dbg_ready, dbg_rsp_valid, dbg_rdata
  );

  modport master (
    output cpu_x, cpu_write, a_reg, a_mem_reg,
    output dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_rsp_ready,
    input  cpu_stall, mem_x, mem_write, dbg_ready, dbg_rsp_valid, dbg_rdata
  );
endinterface

// File: rtl/mem_dbg_arbiter.sv
// Shares the A/D/*A memory block between the CPU and a debug port. A debug access
// stalls the CPU for four cycles: grant, load A, access *A, restore the CPU's A.
module mem_dbg_arbiter #(
  parameter int CPU_SLOTS = 1,
  parameter int DATA_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_dbg_arbiter_if.slave        bus,
  output logic [1:0]              fsm_state
);
  // Handshakes: a debug request transfers on the cycle dbg_valid & dbg_ready are both
  // high; a read response transfers on the cycle dbg_rsp_valid & dbg_rsp_ready are both
  // high. Valid must not depend on ready, and a raised response valid holds its data.

  localparam int GW = (CPU_SLOTS < 1) ? 1 : $clog2(CPU_SLOTS + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_A     = 2'd1,
    ACCESS    = 2'd2,
    RESTORE_A = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     guard_q, guard_d;
  logic [DATA_W-1:0] saved_a_q, saved_a_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic [DATA_W-1:0] mem_x;
  logic [2:0]        mem_write;
  logic              cpu_stall;
  logic              dbg_ready;
  logic              grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      guard_q     <= '0;
      saved_a_q   <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      saved_a_q   <= saved_a_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    saved_a_d   = saved_a_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    mem_x       = bus.cpu_x;
    mem_write   = bus.cpu_write;
    cpu_stall   = 1'b0;
    dbg_ready   = 1'b0;
    grant       = (state_q == IDLE) && bus.dbg_valid && (guard_q == '0) && !rsp_valid_q;

    if (rsp_valid_q && bus.dbg_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (guard_q != '0) begin
          guard_d = guard_q - 1'b1;
        end
        if (grant) begin
          // The CPU's write this cycle is dropped; it re-issues after the stall,
          // so a_reg here is still the pre-instruction A.
          dbg_ready = 1'b1;
          cpu_stall = 1'b1;
          mem_write = 3'b000;
          saved_a_d = bus.a_reg;
          we_d      = bus.dbg_we;
          addr_d    = bus.dbg_addr;
          wdata_d   = bus.dbg_wdata;
          state_d   = SET_A;
        end
      end
      SET_A: begin
        mem_x     = addr_q;
        mem_write = 3'b100;
        cpu_stall = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        cpu_stall = 1'b1;
        mem_x     = we_q ? wdata_q : addr_q;
        mem_write = we_q ? 3'b001 : 3'b000;
        state_d   = RESTORE_A;
      end
      RESTORE_A: begin
        mem_x     = saved_a_q;
        mem_write = 3'b100;
        cpu_stall = 1'b1;
        guard_d   = GW'(CPU_SLOTS);
        if (!we_q) begin
          rdata_d     = bus.a_mem_reg;
          rsp_valid_d = 1'b1;
        end
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Keep the memory block and CPU quiet while reset is held.
    if (!rst_n) begin
      mem_x     = '0;
      mem_write = 3'b000;
      cpu_stall = 1'b0;
      dbg_ready = 1'b0;
    end
  end

  assign bus.mem_x         = mem_x;
  assign bus.mem_write     = mem_write;
  assign bus.cpu_stall     = cpu_stall;
  assign bus.dbg_ready     = dbg_ready;
  assign bus.dbg_rsp_valid = rsp_valid_q;
  assign bus.dbg_rdata     = rdata_q;
  assign fsm_state         = state_q;
endmodule

// File: tb/tb_mem_dbg_arbiter.sv
// Bench for mem_dbg_arbiter: a directed vector table plus hand-written multi-cycle
// sequences, against a behavioural A/D/*A memory block.
module tb_mem_dbg_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] cpu_x = '0;
  logic [2:0]  cpu_write = '0;
  logic        dbg_valid = 1'b0;
  logic        dbg_valid0 = 1'b0;
  logic        dbg_we = 1'b0;
  logic [15:0] dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_rsp_ready = 1'b0;
  logic [1:0]  fsm2;
  logic [1:0]  fsm0;

  mem_dbg_arbiter_if #(.DATA_W(16)) bus2 ();
  mem_dbg_arbiter_if #(.DATA_W(16)) bus0 ();

  mem_dbg_arbiter #(.CPU_SLOTS(2), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .fsm_state(fsm2)
  );
  mem_dbg_arbiter #(.CPU_SLOTS(0), .DATA_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .fsm_state(fsm0)
  );

  // Memory block model for the main instance: A, D and RAM at *A.
  logic [15:0] mem_m [0:65535];
  logic [15:0] a_m = 16'h0000;
  logic [15:0] d_m = 16'h0000;
  logic [15:0] a_mem_q = 16'h0000;

  always @(posedge clk) begin
    if (bus2.mem_write[0]) mem_m[a_m] <= bus2.mem_x;
    if (bus2.mem_write[2]) a_m <= bus2.mem_x;
    if (bus2.mem_write[1]) d_m <= bus2.mem_x;
    a_mem_q <= mem_m[a_m];
  end

  assign bus2.cpu_x         = cpu_x;
  assign bus2.cpu_write     = cpu_write;
  assign bus2.a_reg         = a_m;
  assign bus2.a_mem_reg     = a_mem_q;
  assign bus2.dbg_valid     = dbg_valid;
  assign bus2.dbg_we        = dbg_we;
  assign bus2.dbg_addr      = dbg_addr;
  assign bus2.dbg_wdata     = dbg_wdata;
  assign bus2.dbg_rsp_ready = dbg_rsp_ready;

  assign bus0.cpu_x         = cpu_x;
  assign bus0.cpu_write     = cpu_write;
  assign bus0.a_reg         = 16'h0000;
  assign bus0.a_mem_reg     = 16'h0000;
  assign bus0.dbg_valid     = dbg_valid0;
  assign bus0.dbg_we        = dbg_we;
  assign bus0.dbg_addr      = dbg_addr;
  assign bus0.dbg_wdata     = dbg_wdata;
  assign bus0.dbg_rsp_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic cyc(input logic [15:0] x, input logic [2:0] w);
    @(negedge clk);
    cpu_x = x;
    cpu_write = w;
    #1;
  endtask

  typedef struct {
    logic [15:0] cpu_x;
    logic [2:0]  cpu_write;
    logic        dbg_valid;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_wdata;
    logic        chk_x;
    logic [15:0] exp_x;
    logic [2:0]  exp_w;
    logic        exp_stall;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [11];

  // Hold dbg_valid on the selected instance until two grants are seen and count the
  // unstalled cycles between them.
  task automatic gap_test(input bit sel0, input int exp_gap, input logic [15:0] addr);
    int gap = 0;
    int grants = 0;
    logic rdy;
    logic stl;
    @(negedge clk);
    dbg_we = 1'b1;
    dbg_addr = addr;
    dbg_wdata = addr ^ 16'h5A5A;
    cpu_write = 3'b000;
    if (sel0) dbg_valid0 = 1'b1; else dbg_valid = 1'b1;
    for (int k = 0; k < 60 && grants < 2; k++) begin
      #1;
      rdy = sel0 ? bus0.dbg_ready : bus2.dbg_ready;
      stl = sel0 ? bus0.cpu_stall : bus2.cpu_stall;
      if (grants == 1 && !stl) gap++;
      if (rdy) grants++;
      if (grants < 2) @(negedge clk);
    end
    @(negedge clk);
    dbg_valid = 1'b0;
    dbg_valid0 = 1'b0;
    chk(sel0 ? "gap0_grants" : "gap2_grants", grants, 2);
    chk(sel0 ? "gap0_idle_cycles" : "gap2_idle_cycles", gap, exp_gap);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 3'b110, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 3'b110, 1'b0, 1'b0};
    vecs[1]  = '{16'h0042, 3'b100, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0042, 3'b100, 1'b0, 1'b0};
    vecs[2]  = '{16'hFFFF, 3'b001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 3'b001, 1'b0, 1'b0};
    vecs[3]  = '{16'h0000, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b000, 1'b0, 1'b0};
    // Debug write: grant (CPU *A write suppressed), SET_A, ACCESS, RESTORE_A.
    vecs[4]  = '{16'h5555, 3'b001, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0000, 3'b000, 1'b1, 1'b1};
    vecs[5]  = '{16'h5555, 3'b001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0100, 3'b100, 1'b1, 1'b0};
    vecs[6]  = '{16'h5555, 3'b001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBEEF, 3'b001, 1'b1, 1'b0};
    vecs[7]  = '{16'h5555, 3'b001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0042, 3'b100, 1'b1, 1'b0};
    // Guard still running: a one-cycle request is not taken and leaves no trace.
    vecs[8]  = '{16'h7777, 3'b000, 1'b1, 1'b1, 16'h0999, 16'h1111, 1'b1, 16'h7777, 3'b000, 1'b0, 1'b0};
    vecs[9]  = '{16'h1111, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111, 3'b000, 1'b0, 1'b0};
    vecs[10] = '{16'h2222, 3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h2222, 3'b000, 1'b0, 1'b0};

    // Reset values with busy-looking inputs.
    cpu_x = 16'h1234;
    cpu_write = 3'b111;
    dbg_valid = 1'b1;
    #3;
    chk("rst_mem_x", bus2.mem_x, 16'h0000);
    chk("rst_mem_write", bus2.mem_write, 3'b000);
    chk("rst_cpu_stall", bus2.cpu_stall, 1'b0);
    chk("rst_dbg_ready", bus2.dbg_ready, 1'b0);
    chk("rst_rsp_valid", bus2.dbg_rsp_valid, 1'b0);
    chk("rst_rdata", bus2.dbg_rdata, 16'h0000);
    chk("rst_state", fsm2, 2'd0);
    @(negedge clk);
    dbg_valid = 1'b0;
    cpu_write = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cpu_x = vecs[i].cpu_x;
      cpu_write = vecs[i].cpu_write;
      dbg_valid = vecs[i].dbg_valid;
      dbg_we = vecs[i].dbg_we;
      dbg_addr = vecs[i].dbg_addr;
      dbg_wdata = vecs[i].dbg_wdata;
      #1;
      if (vecs[i].chk_x) chk($sformatf("vec%0d_mem_x", i), bus2.mem_x, vecs[i].exp_x);
      chk($sformatf("vec%0d_mem_write", i), bus2.mem_write, vecs[i].exp_w);
      chk($sformatf("vec%0d_cpu_stall", i), bus2.cpu_stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d_dbg_ready", i), bus2.dbg_ready, vecs[i].exp_ready);
    end
    dbg_valid = 1'b0;
    chk("wr_mem_0100", mem_m[16'h0100], 16'hBEEF);
    chk("wr_mem_0042", mem_m[16'h0042], 16'hFFFF);
    chk("wr_a_restored", bus2.a_reg, 16'h0042);

    // Debug read of a preloaded location, then response backpressure.
    cyc(16'h0200, 3'b100);
    cyc(16'hCAFE, 3'b001);
    cyc(16'h0007, 3'b100);
    @(negedge clk);
    cpu_x = 16'h0000;
    cpu_write = 3'b000;
    dbg_valid = 1'b1;
    dbg_we = 1'b0;
    dbg_addr = 16'h0200;
    #1;
    chk("rd_grant_ready", bus2.dbg_ready, 1'b1);
    chk("rd_grant_stall", bus2.cpu_stall, 1'b1);
    @(negedge clk);
    dbg_valid = 1'b0;
    #1;
    chk("rd_set_a_x", bus2.mem_x, 16'h0200);
    chk("rd_set_a_w", bus2.mem_write, 3'b100);
    @(negedge clk);
    #1;
    chk("rd_access_w", bus2.mem_write, 3'b000);
    chk("rd_access_stall", bus2.cpu_stall, 1'b1);
    @(negedge clk);
    #1;
    chk("rd_restore_x", bus2.mem_x, 16'h0007);
    chk("rd_restore_w", bus2.mem_write, 3'b100);
    chk("rd_restore_rsp_low", bus2.dbg_rsp_valid, 1'b0);
    @(negedge clk);
    dbg_valid = 1'b1;
    dbg_we = 1'b1;
    dbg_addr = 16'h0300;
    dbg_wdata = 16'h1357;
    cpu_x = 16'h4444;
    cpu_write = 3'b000;
    #1;
    chk("rd_a_restored", bus2.a_reg, 16'h0007);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("bp%0d_rsp_valid", i), bus2.dbg_rsp_valid, 1'b1);
      chk($sformatf("bp%0d_rdata", i), bus2.dbg_rdata, 16'hCAFE);
      chk($sformatf("bp%0d_no_ready", i), bus2.dbg_ready, 1'b0);
      chk($sformatf("bp%0d_no_stall", i), bus2.cpu_stall, 1'b0);
      chk($sformatf("bp%0d_passthru", i), bus2.mem_x, 16'h4444);
    end
    @(negedge clk);
    dbg_rsp_ready = 1'b1;
    #1;
    chk("take_rsp_valid", bus2.dbg_rsp_valid, 1'b1);
    chk("take_no_ready", bus2.dbg_ready, 1'b0);
    @(negedge clk);
    dbg_rsp_ready = 1'b0;
    #1;
    chk("taken_rsp_clear", bus2.dbg_rsp_valid, 1'b0);
    chk("taken_grant", bus2.dbg_ready, 1'b1);
    @(negedge clk);
    dbg_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("bp_wr_mem_0300", mem_m[16'h0300], 16'h1357);
    chk("bp_wr_a_restored", bus2.a_reg, 16'h0007);
    chk("d_untouched", d_m, 16'h1234);

    gap_test(1'b0, 2, 16'h0500);
    gap_test(1'b1, 0, 16'h0600);

    // Reset asserted during the ACCESS cycle of a write.
    @(negedge clk);
    cpu_x = 16'h9999;
    cpu_write = 3'b011;
    dbg_valid = 1'b1;
    dbg_we = 1'b1;
    dbg_addr = 16'h0400;
    dbg_wdata = 16'h2468;
    begin
      int waited = 0;
      #1;
      while (!bus2.dbg_ready && waited < 10) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk("ro_grant_seen", bus2.dbg_ready, 1'b1);
    end
    @(negedge clk);
    dbg_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("ro_access_w", bus2.mem_write, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ro_mem_write", bus2.mem_write, 3'b000);
    chk("ro_mem_x", bus2.mem_x, 16'h0000);
    chk("ro_cpu_stall", bus2.cpu_stall, 1'b0);
    chk("ro_state", fsm2, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(16'hABCD, 3'b010);
    chk("post_rst_x", bus2.mem_x, 16'hABCD);
    chk("post_rst_w", bus2.mem_write, 3'b010);
    chk("post_rst_stall", bus2.cpu_stall, 1'b0);
    chk("post_rst_rsp", bus2.dbg_rsp_valid, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
